// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit (one bit per cycle) with MADD/MSUB accumulate and annul.
// Ports: clk/rst (sync, active-high); start_i/annul_i/op_i request control;
// opdata1_i/opdata2_i operands; acc_hi_i/acc_lo_i accumulator for MADD/MSUB;
// result_hi_o/result_lo_o registered result; ready_o one-cycle done pulse;
// busy_o unit occupied; stallreq_o combinational pipeline stall request.
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             stallreq_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DIVZERO, DONE} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div, r_mac, r_sub, r_neg, r_rneg, r_ready;
  logic [2*WIDTH-1:0] r_x, r_y, r_acc;
  logic [WIDTH-1:0]   r_m, r_hi, r_lo;
  logic               w_isdiv, w_n1, w_n2, w_ge;
  logic [WIDTH-1:0]   w_a, w_b, w_rem, w_q, w_r;
  logic [WIDTH:0]     w_top;
  logic [2*WIDTH-1:0] w_dstep, w_next, w_p, w_res;
  assign w_isdiv = op_i[2:1] == 2'b01;
  assign w_n1    = ~op_i[0] & opdata1_i[WIDTH-1];
  assign w_n2    = ~op_i[0] & opdata2_i[WIDTH-1];
  assign w_a     = w_n1 ? -opdata1_i : opdata1_i;
  assign w_b     = w_n2 ? -opdata2_i : opdata2_i;
  // Divide: r_x holds {remainder, dividend bits still to shift in}; r_y[W-1:0] holds the divisor.
  // The shifted remainder needs WIDTH+1 bits; the difference always fits WIDTH bits when taken.
  assign w_top   = r_x[2*WIDTH-1:WIDTH-1];
  assign w_ge    = w_top >= {1'b0, r_y[WIDTH-1:0]};
  assign w_rem   = w_top[WIDTH-1:0] - r_y[WIDTH-1:0];
  assign w_dstep = w_ge ? {w_rem, r_x[WIDTH-2:0], 1'b1} : {r_x[2*WIDTH-2:0], 1'b0};
  // Multiply: r_x accumulates, r_y is the left-shifting multiplicand, r_m the right-shifting multiplier.
  assign w_next  = r_div ? w_dstep : (r_m[0] ? r_x + r_y : r_x);
  assign w_q     = r_neg ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
  assign w_r     = r_rneg ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];
  assign w_p     = r_neg ? -w_next : w_next;
  assign w_res   = r_div ? {w_r, w_q} : (!r_mac ? w_p : r_sub ? r_acc - w_p : r_acc + w_p);
  assign result_hi_o = r_hi;
  assign result_lo_o = r_lo;
  assign ready_o     = r_ready;
  assign busy_o      = r_state != IDLE;
  assign stallreq_o  = !rst && !annul_i &&
                       (r_state == BUSY || r_state == DIVZERO || (r_state == IDLE && start_i));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_mac   <= 1'b0;
      r_sub   <= 1'b0;
      r_neg   <= 1'b0;
      r_rneg  <= 1'b0;
      r_ready <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: if (start_i && !annul_i) begin
          r_state <= (w_isdiv && opdata2_i == '0) ? DIVZERO : BUSY;
          r_cnt   <= '0;
          r_div   <= w_isdiv;
          r_mac   <= op_i[2];
          r_sub   <= op_i[1];
          r_neg   <= w_n1 ^ w_n2;
          r_rneg  <= w_n1;
          r_x     <= w_isdiv ? {{WIDTH{1'b0}}, w_a} : '0;
          r_y     <= {{WIDTH{1'b0}}, w_isdiv ? w_b : w_a};
          r_m     <= w_b;
          r_acc   <= {acc_hi_i, acc_lo_i};
        end
        BUSY: if (annul_i) r_state <= IDLE;
        else begin
          r_x   <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (!r_div) begin
            r_y <= r_y << 1;
            r_m <= r_m >> 1;
          end
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= DONE;
            {r_hi, r_lo} <= w_res;
            r_ready <= 1'b1;
          end
        end
        DIVZERO: if (annul_i) r_state <= IDLE;
        else begin
          r_state <= DONE;
          r_hi    <= '0;
          r_lo    <= '0;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed and random self-checking bench for ex_muldiv with a result scoreboard.
module tb_ex_muldiv;
  localparam int W = 32;
  logic         clk = 1'b0, rst = 1'b1, start_i = 1'b0, annul_i = 1'b0;
  logic [2:0]   op_i = '0;
  logic [W-1:0] opdata1_i = '0, opdata2_i = '0, acc_hi_i = '0, acc_lo_i = '0;
  logic [W-1:0] result_hi_o, result_lo_o;
  logic         ready_o, busy_o, stallreq_o;
  int           total = 0, passed = 0;
  logic [63:0]  sb[$];
  logic [63:0]  last_res = '0;
  ex_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .acc_hi_i(acc_hi_i), .acc_lo_i(acc_lo_i),
    .result_hi_o(result_hi_o), .result_lo_o(result_lo_o),
    .ready_o(ready_o), .busy_o(busy_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, ah, al);
    logic signed [31:0] sa, sd;
    logic [63:0] p;
    sa = a;
    sd = b;
    p = op[0] ? {32'b0, a} * {32'b0, b} : {{32{a[31]}}, a} * {{32{b[31]}}, b};
    case (op[2:1])
      2'b00: return p;
      2'b10: return {ah, al} + p;
      2'b11: return {ah, al} - p;
      default: begin
        if (b == 0) return 64'h0;
        if (op[0]) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return {32'h0, a};
        return {32'(sa % sd), 32'(sa / sd)};
      end
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, b, ah, al,
                        input logic [63:0] exp, input int exp_lat, input bit hold);
    int lat, bcnt;
    logic [63:0] got;
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b0; op_i = op;
    opdata1_i = a; opdata2_i = b; acc_hi_i = ah; acc_lo_i = al;
    #1 chk({tag, "_stall_at_start"}, 64'(stallreq_o), 64'd1);
    sb.push_back(exp);
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
    acc_hi_i = $urandom; acc_lo_i = $urandom;
    lat = 1;
    bcnt = int'(busy_o);
    while (!ready_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      bcnt += int'(busy_o);
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    got = sb.pop_front();
    if (ready_o) begin
      chk({tag, "_result"}, {result_hi_o, result_lo_o}, got);
      chk({tag, "_stall_in_done"}, 64'(stallreq_o), 64'd0);
      last_res = got;
    end
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ready_pulse_end"}, 64'(ready_o), 64'd0);
    chk({tag, "_idle_after"}, 64'(busy_o), 64'd0);
  endtask
  initial begin
    int rdy;
    logic [2:0] rop;
    logic [31:0] ra, rb, rh, rl;
    start_i = 1'b1;
    annul_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", {result_hi_o, result_lo_o}, 64'h0);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    #1 chk("reset_stall_overrides_start", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    chk("reset_start_ignored", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    run_op("mult", 3'b000, 32'hffff_ffff, 32'h5, 0, 0, {32'hffff_ffff, 32'hffff_fffb}, 33, 0);
    run_op("multu", 3'b001, 32'hffff_ffff, 32'hffff_ffff, 0, 0, 64'hffff_fffe_0000_0001, 33, 0);
    run_op("divu", 3'b011, 32'd100, 32'd7, 0, 0, {32'd2, 32'd14}, 33, 0);
    run_op("div_neg", 3'b010, 32'hffff_fff9, 32'd2, 0, 0, {32'hffff_ffff, 32'hffff_fffd}, 33, 0);
    run_op("div_minneg", 3'b010, 32'h8000_0000, 32'hffff_ffff, 0, 0, {32'h0, 32'h8000_0000}, 33, 0);
    run_op("div_zero", 3'b010, 32'd5, 32'd0, 0, 0, 64'h0, 2, 0);
    run_op("divu_zero", 3'b011, 32'hdead_beef, 32'd0, 0, 0, 64'h0, 2, 0);
    run_op("msubu", 3'b111, 32'd3, 32'd5, 32'd0, 32'd10, {32'hffff_ffff, 32'hffff_fffb}, 33, 0);
    run_op("madd", 3'b100, 32'hffff_ffff, 32'd1, 32'd1, 32'd0, {32'h0, 32'hffff_ffff}, 33, 0);
    run_op("msub_sign", 3'b110, 32'hffff_fffe, 32'd3, 32'd0, 32'd4, 64'd10, 33, 0);
    run_op("start_held", 3'b000, 32'd7, 32'hffff_fffd, 0, 0, 64'hffff_ffff_ffff_ffeb, 33, 1);
    for (int i = 0; i < 8; i++) begin
      rop = 3'(i);
      ra = $urandom;
      rb = $urandom;
      rh = $urandom;
      rl = $urandom;
      if (rop[2:1] == 2'b01 && rb == 0) rb = 32'd3;
      if (i == 3) rb = 32'd0 - 32'(i + 5);
      run_op("random", rop, ra, rb, rh, rl, model(rop, ra, rb, rh, rl), 33, 0);
    end
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; opdata1_i = 32'd3; opdata2_i = 32'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    #1 chk("annul_busy_stall_now", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_busy_idle", 64'(busy_o), 64'd0);
    chk("annul_busy_stall", 64'(stallreq_o), 64'd0);
    chk("annul_busy_no_ready", 64'(ready_o), 64'd0);
    chk("annul_busy_result_kept", {result_hi_o, result_lo_o}, last_res);
    run_op("after_annul", 3'b101, 32'h1234_5678, 32'h9abc_def0, 32'h1, 32'h2,
           model(3'b101, 32'h1234_5678, 32'h9abc_def0, 32'h1, 32'h2), 33, 0);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b011; opdata1_i = 32'd9; opdata2_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_divzero_idle", 64'(busy_o), 64'd0);
    chk("annul_divzero_no_ready", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    chk("annul_divzero_still_no_ready", 64'(ready_o), 64'd0);
    chk("annul_divzero_result_kept", {result_hi_o, result_lo_o}, last_res);
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b010; opdata1_i = 32'd9; opdata2_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b1;
    #1 chk("annul_done_ready", 64'(ready_o), 64'd1);
    chk("annul_done_stall", 64'(stallreq_o), 64'd0);
    chk("annul_done_result", {result_hi_o, result_lo_o}, 64'h0);
    last_res = 64'h0;
    @(posedge clk); #1;
    chk("annul_done_idle", 64'(busy_o), 64'd0);
    @(negedge clk);
    start_i = 1'b1;
    annul_i = 1'b1;
    op_i = 3'b000;
    opdata1_i = 32'd6;
    opdata2_i = 32'd7;
    #1 chk("start_annul_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    chk("start_annul_not_started", 64'(busy_o), 64'd0);
    annul_i = 1'b0;
    @(posedge clk); #1;
    chk("start_held_accepted", 64'(busy_o), 64'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_result", {result_hi_o, result_lo_o}, 64'h0);
    chk("rst_mid_ready", 64'(ready_o), 64'd0);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    chk("rst_mid_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      rdy += int'(ready_o);
    end
    chk("rst_mid_no_ready_after", 64'(rdy), 64'd0);
    chk("rst_mid_stays_idle", 64'(busy_o), 64'd0);
    run_op("after_rst", 3'b011, 32'hffff_fff0, 32'd16, 0, 0, {32'd0, 32'h0fff_ffff}, 33, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
